dcache_miss_ctrl: RTL and testbench
===================================

# dcache_miss_ctrl

Miss-handling controller between the core's load/store port and `data_cache`. It turns single-word CPU requests into cache lookups. On a miss it writes back the evicted line, fetches the missing 512-bit line from memory and loads it via `ld`, then replays the access. It owns every `data_cache` control input and is the only memory-side master for data lines.

## Interface
Parameters:
- `TAG_BITS`, default 18, tag width; address [31:14].
- `INDEX_BITS`, default 10, line index; address [13:4].
- `OFFSET_BITS`, default 4, word offset; address [3:0], word-addressed.
- `BLOCK_SIZE`, default 512, line width in bits.

Ports:
- `clk`  in  1  sole clock; one clock; reset is asynchronous and active-low.
- `rst`  in  1  asynchronous, active-low reset.
- `cpuReq`  in  1  request; held with `cpuWr`, `cpuAddr`, `cpuDataIn` stable until `cpuDone`.
- `cpuWr`  in  1  1 = store, 0 = load.
- `cpuAddr`  in  32  word address.
- `cpuDataIn`  in  32  store data.
- `cpuDataOut`  out  32  load data, registered, valid with `cpuDone`.
- `cpuDone`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in any state except IDLE.
- `cacheEn`, `cacheRd`, `cacheWr`, `cacheLd`  out  1 each  `data_cache` `en`/`rd`/`wr`/`ld`.
- `cacheAddr`  out  32  `data_cache` `addr`.
- `cacheDataIn`  out  32  `data_cache` `dataIn`.
- `cacheBlkIn`  out  512  `data_cache` `blkIn`.
- `cacheDataOut`  in  32  `data_cache` `dataOut`.
- `cacheHit`, `cacheMiss`, `cacheEvict`  in  1 each  `data_cache` status.
- `cacheBlkOut`  in  512  victim line, valid with `cacheEvict`.
- `cacheTagOut`  in  18  victim tag, valid with `cacheEvict`.
- `memRd`, `memWr`  out  1 each  line read / line write request; level, held until `memAck`.
- `memAddr`  out  32  line address, [3:0] = 0.
- `memBlkOut`  out  512  writeback data.
- `memBlkIn`  in  512  fill data, valid with `memAck` during a read.
- `memAck`  in  1  one-cycle completion of the current memory request.

## Operation
- States: IDLE, LOOKUP, CHECK, WB, FILL, LOAD, DONE.
- IDLE:
  - `cpuReq` latches the request into `reqAddr`, `reqWr` and `reqData`.
  - Next state is LOOKUP.
- LOOKUP:
  - Drives `cacheEn=1` and `cacheAddr=reqAddr`.
  - Load drives `cacheRd=1`; store drives `cacheWr=1` with `cacheDataIn=reqData`.
  - Next state is CHECK.
- CHECK (samples cache status):
  - `cacheHit`: latch `cacheDataOut` into `cpuDataOut` for loads only, then DONE.
  - `cacheMiss & cacheEvict`: latch `cacheBlkOut` and `cacheTagOut`, then WB.
  - `cacheMiss & !cacheEvict`: FILL.
  - Hit and miss both high: treated as miss.
  - Neither high: treated as miss.
- WB:
  - `memWr=1`, `memAddr={victimTag, reqAddr[13:4], 4'b0}`, `memBlkOut` = latched line.
  - On `memAck`, go to FILL.
- FILL:
  - `memRd=1`, `memAddr={reqAddr[31:4], 4'b0}`.
  - On `memAck`, latch `memBlkIn`, then LOAD.
- LOAD:
  - Drives `cacheEn=1`, `cacheLd=1`, `cacheAddr=reqAddr`, `cacheBlkIn` = fill line.
  - Next state is LOOKUP; the replay must hit.
  - A second miss on replay repeats the miss sequence. It is not an error.
- DONE: `cpuDone=1` for one cycle, then IDLE.
- `memRd` and `memWr` are never high together.
- All cache controls are 0 outside LOOKUP and LOAD.
- `memAck` outside WB/FILL is ignored.
- `cpuReq` outside IDLE is ignored; the request is already latched.

## Timing
- Reset values: all outputs 0, state IDLE, latched request/line registers 0.
- Reset mid-operation:
  - Immediate IDLE; `memRd`/`memWr` drop asynchronously.
  - No `cpuDone`.
  - A later stray `memAck` is ignored.
- `data_cache` status is sampled in CHECK, one cycle after the LOOKUP drive.
- Hit: accept edge in IDLE → `cpuDone` high 3 cycles later (LOOKUP, CHECK, DONE).
- Clean miss: 3 + F + 3 cycles, where F = FILL cycles including the `memAck` cycle (LOOKUP, CHECK, FILL×F, LOAD, LOOKUP, CHECK, DONE).
- Dirty miss: adds W WB cycles.
- `memAck` in the first WB/FILL cycle is legal (W or F = 1).
- Back-to-back: a new `cpuReq` is accepted in the IDLE cycle after DONE.

## Configuration
- `DCACHE_CTRL_STATS_EN` defined:
  - Adds output ports `hitCount` [31:0], `missCount` [31:0] and `evictCount` [31:0].
  - Each increments once per request classification in the first CHECK only; replays are not counted.
  - Saturating at 32'hFFFF_FFFF; reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset with `rst=0` mid-FILL (memRd=1) → `memRd=0` immediately, IDLE, no `cpuDone`; a following `memAck` causes no state change.
- Cold load to 32'h0000_0016, memory returns line words 16..31 after F=4 → `memAddr`=32'h0000_0010, one `cacheLd` cycle, `cpuDataOut`=22, `cpuDone` 10 cycles after accept.
- Load hit on the same line at 32'h0000_0011 → `cpuDataOut`=17, `cpuDone` 3 cycles after accept, `memRd`/`memWr` stay 0.
- Store 32'hFFFF_FFFF to 32'h0000_0011, then load 32'h0000_0011 → both hit, read returns 32'hFFFF_FFFF.
- Miss with `cacheEvict=1` and `cacheTagOut`=18'h1 at index 1 → `memWr` first with `memAddr`=32'h0000_4010 and `memBlkOut`=`cacheBlkOut`, then `memRd`, never overlapping.
- With `DCACHE_CTRL_STATS_EN`: run 1 cold miss, 2 hits and 1 evicting miss → `hitCount`=2, `missCount`=2, `evictCount`=1.

Source files
------------

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl
// Miss-handling controller between the core load/store port and data_cache.
// A single-word CPU request becomes a cache lookup. On a miss the controller
// writes back a dirty victim, fetches the missing line, loads it into the cache
// and replays the access.
// Optional build macro DCACHE_CTRL_STATS_EN adds saturating hit/miss/evict
// counters that count the first classification of each request only.
// Every output is registered. Each output is decoded from the next state and
// from the next values of the latched registers, so it is valid during the
// state that it belongs to.
module dcache_miss_ctrl #(
    parameter int TAG_BITS    = 18,
    parameter int INDEX_BITS  = 10,
    parameter int OFFSET_BITS = 4,
    parameter int BLOCK_SIZE  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpuReq,
    input  logic                  cpuWr,
    input  logic [31:0]           cpuAddr,
    input  logic [31:0]           cpuDataIn,
    output logic [31:0]           cpuDataOut,
    output logic                  cpuDone,
    output logic                  busy,
    output logic                  cacheEn,
    output logic                  cacheRd,
    output logic                  cacheWr,
    output logic                  cacheLd,
    output logic [31:0]           cacheAddr,
    output logic [31:0]           cacheDataIn,
    output logic [BLOCK_SIZE-1:0] cacheBlkIn,
    input  logic [31:0]           cacheDataOut,
    input  logic                  cacheHit,
    input  logic                  cacheMiss,
    input  logic                  cacheEvict,
    input  logic [BLOCK_SIZE-1:0] cacheBlkOut,
    input  logic [TAG_BITS-1:0]   cacheTagOut,
    output logic                  memRd,
    output logic                  memWr,
    output logic [31:0]           memAddr,
    output logic [BLOCK_SIZE-1:0] memBlkOut,
    input  logic [BLOCK_SIZE-1:0] memBlkIn,
    input  logic                  memAck
`ifdef DCACHE_CTRL_STATS_EN
    ,
    output logic [31:0]           hitCount,
    output logic [31:0]           missCount,
    output logic [31:0]           evictCount
`endif
);

    localparam int IDX_LO = OFFSET_BITS;
    localparam int IDX_HI = OFFSET_BITS + INDEX_BITS - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WB     = 3'd3,
        ST_FILL   = 3'd4,
        ST_LOAD   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t                state_r;
    state_t                next_state_s;

    logic [31:0]           req_addr_r;
    logic                  req_wr_r;
    logic [31:0]           req_data_r;
    logic [BLOCK_SIZE-1:0] victim_blk_r;
    logic [TAG_BITS-1:0]   victim_tag_r;
    logic [BLOCK_SIZE-1:0] fill_blk_r;

    logic [31:0]           req_addr_nxt_s;
    logic                  req_wr_nxt_s;
    logic [31:0]           req_data_nxt_s;
    logic [BLOCK_SIZE-1:0] victim_blk_nxt_s;
    logic [TAG_BITS-1:0]   victim_tag_nxt_s;
    logic [BLOCK_SIZE-1:0] fill_blk_nxt_s;

    logic                  cpu_done_d_s;
    logic                  busy_d_s;
    logic                  cache_en_d_s;
    logic                  cache_rd_d_s;
    logic                  cache_wr_d_s;
    logic                  cache_ld_d_s;
    logic [31:0]           cache_addr_d_s;
    logic [31:0]           cache_data_in_d_s;
    logic [BLOCK_SIZE-1:0] cache_blk_in_d_s;
    logic                  mem_rd_d_s;
    logic                  mem_wr_d_s;
    logic [31:0]           mem_addr_d_s;
    logic [BLOCK_SIZE-1:0] mem_blk_out_d_s;

    // A clean hit needs hit without miss; anything else is handled as a miss.
    logic hit_s;
    logic evict_s;
    assign hit_s   = cacheHit & ~cacheMiss;
    assign evict_s = cacheMiss & cacheEvict;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = cpuReq ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP: next_state_s = ST_CHECK;
            ST_CHECK: begin
                if (hit_s) begin
                    next_state_s = ST_DONE;
                end else if (evict_s) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_WB:     next_state_s = memAck ? ST_FILL : ST_WB;
            ST_FILL:   next_state_s = memAck ? ST_LOAD : ST_FILL;
            ST_LOAD:   next_state_s = ST_LOOKUP;
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the latched request, victim line and fill line
    always_comb begin
        if ((state_r == ST_IDLE) && cpuReq) begin
            req_addr_nxt_s = cpuAddr;
            req_wr_nxt_s   = cpuWr;
            req_data_nxt_s = cpuDataIn;
        end else begin
            req_addr_nxt_s = req_addr_r;
            req_wr_nxt_s   = req_wr_r;
            req_data_nxt_s = req_data_r;
        end
        if ((state_r == ST_CHECK) && evict_s) begin
            victim_blk_nxt_s = cacheBlkOut;
            victim_tag_nxt_s = cacheTagOut;
        end else begin
            victim_blk_nxt_s = victim_blk_r;
            victim_tag_nxt_s = victim_tag_r;
        end
        if ((state_r == ST_FILL) && memAck) begin
            fill_blk_nxt_s = memBlkIn;
        end else begin
            fill_blk_nxt_s = fill_blk_r;
        end
    end

    // Latched request, victim and fill registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr_r   <= 32'd0;
            req_wr_r     <= 1'b0;
            req_data_r   <= 32'd0;
            victim_blk_r <= {BLOCK_SIZE{1'b0}};
            victim_tag_r <= {TAG_BITS{1'b0}};
            fill_blk_r   <= {BLOCK_SIZE{1'b0}};
        end else begin
            req_addr_r   <= req_addr_nxt_s;
            req_wr_r     <= req_wr_nxt_s;
            req_data_r   <= req_data_nxt_s;
            victim_blk_r <= victim_blk_nxt_s;
            victim_tag_r <= victim_tag_nxt_s;
            fill_blk_r   <= fill_blk_nxt_s;
        end
    end

    // Output decode from the state being entered
    always_comb begin
        cpu_done_d_s      = 1'b0;
        busy_d_s          = (next_state_s != ST_IDLE);
        cache_en_d_s      = 1'b0;
        cache_rd_d_s      = 1'b0;
        cache_wr_d_s      = 1'b0;
        cache_ld_d_s      = 1'b0;
        cache_addr_d_s    = 32'd0;
        cache_data_in_d_s = 32'd0;
        cache_blk_in_d_s  = {BLOCK_SIZE{1'b0}};
        mem_rd_d_s        = 1'b0;
        mem_wr_d_s        = 1'b0;
        mem_addr_d_s      = 32'd0;
        mem_blk_out_d_s   = {BLOCK_SIZE{1'b0}};
        case (next_state_s)
            ST_LOOKUP: begin
                cache_en_d_s      = 1'b1;
                cache_addr_d_s    = req_addr_nxt_s;
                cache_rd_d_s      = ~req_wr_nxt_s;
                cache_wr_d_s      = req_wr_nxt_s;
                cache_data_in_d_s = req_wr_nxt_s ? req_data_nxt_s : 32'd0;
            end
            ST_WB: begin
                mem_wr_d_s      = 1'b1;
                mem_addr_d_s    = {victim_tag_nxt_s, req_addr_nxt_s[IDX_HI:IDX_LO],
                                   {OFFSET_BITS{1'b0}}};
                mem_blk_out_d_s = victim_blk_nxt_s;
            end
            ST_FILL: begin
                mem_rd_d_s   = 1'b1;
                mem_addr_d_s = {req_addr_nxt_s[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
            ST_LOAD: begin
                cache_en_d_s     = 1'b1;
                cache_ld_d_s     = 1'b1;
                cache_addr_d_s   = req_addr_nxt_s;
                cache_blk_in_d_s = fill_blk_nxt_s;
            end
            ST_DONE: cpu_done_d_s = 1'b1;
            default: cpu_done_d_s = 1'b0;
        endcase
    end

    // Output registers; reset drops memory requests asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpuDone     <= 1'b0;
            busy        <= 1'b0;
            cacheEn     <= 1'b0;
            cacheRd     <= 1'b0;
            cacheWr     <= 1'b0;
            cacheLd     <= 1'b0;
            cacheAddr   <= 32'd0;
            cacheDataIn <= 32'd0;
            cacheBlkIn  <= {BLOCK_SIZE{1'b0}};
            memRd       <= 1'b0;
            memWr       <= 1'b0;
            memAddr     <= 32'd0;
            memBlkOut   <= {BLOCK_SIZE{1'b0}};
        end else begin
            cpuDone     <= cpu_done_d_s;
            busy        <= busy_d_s;
            cacheEn     <= cache_en_d_s;
            cacheRd     <= cache_rd_d_s;
            cacheWr     <= cache_wr_d_s;
            cacheLd     <= cache_ld_d_s;
            cacheAddr   <= cache_addr_d_s;
            cacheDataIn <= cache_data_in_d_s;
            cacheBlkIn  <= cache_blk_in_d_s;
            memRd       <= mem_rd_d_s;
            memWr       <= mem_wr_d_s;
            memAddr     <= mem_addr_d_s;
            memBlkOut   <= mem_blk_out_d_s;
        end
    end

    // Load data capture on a hit; it is held through DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpuDataOut <= 32'd0;
        end else if ((state_r == ST_CHECK) && hit_s && !req_wr_r) begin
            cpuDataOut <= cacheDataOut;
        end
    end

`ifdef DCACHE_CTRL_STATS_EN
    // Saturating increment for the statistics counters
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    logic replay_r;

    // Marks a request that has been through LOAD so replays are not recounted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            replay_r <= 1'b0;
        end else if (state_r == ST_LOAD) begin
            replay_r <= 1'b1;
        end
    end

    // Classification counters, first CHECK of each request only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitCount   <= 32'd0;
            missCount  <= 32'd0;
            evictCount <= 32'd0;
        end else if ((state_r == ST_CHECK) && !replay_r) begin
            if (hit_s) begin
                hitCount <= sat_inc(hitCount);
            end else begin
                missCount <= sat_inc(missCount);
                if (evict_s) begin
                    evictCount <= sat_inc(evictCount);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl: behavioural data_cache and memory
// around the DUT, directed scenarios plus randomized traffic that is checked
// against a word-level reference of memory contents and cache residency.
module tb_dcache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpuReq, cpuWr;
    logic [31:0]  cpuAddr, cpuDataIn, cpuDataOut;
    logic         cpuDone, busy;
    logic         cacheEn, cacheRd, cacheWr, cacheLd;
    logic [31:0]  cacheAddr, cacheDataIn, cacheDataOut;
    logic [511:0] cacheBlkIn, cacheBlkOut;
    logic         cacheHit, cacheMiss, cacheEvict;
    logic [17:0]  cacheTagOut;
    logic         memRd, memWr, memAck;
    logic [31:0]  memAddr;
    logic [511:0] memBlkOut, memBlkIn;
`ifdef DCACHE_CTRL_STATS_EN
    logic [31:0]  hitCount, missCount, evictCount;
`endif

    int n_pass = 0;
    int n_total = 0;
    int lat_w = 1;
    int lat_f = 1;
    logic stray_ack = 1'b0;

    dcache_miss_ctrl dut (
        .clk(clk), .rst(rst),
        .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuAddr(cpuAddr), .cpuDataIn(cpuDataIn),
        .cpuDataOut(cpuDataOut), .cpuDone(cpuDone), .busy(busy),
        .cacheEn(cacheEn), .cacheRd(cacheRd), .cacheWr(cacheWr), .cacheLd(cacheLd),
        .cacheAddr(cacheAddr), .cacheDataIn(cacheDataIn), .cacheBlkIn(cacheBlkIn),
        .cacheDataOut(cacheDataOut), .cacheHit(cacheHit), .cacheMiss(cacheMiss),
        .cacheEvict(cacheEvict), .cacheBlkOut(cacheBlkOut), .cacheTagOut(cacheTagOut),
        .memRd(memRd), .memWr(memWr), .memAddr(memAddr), .memBlkOut(memBlkOut),
        .memBlkIn(memBlkIn), .memAck(memAck)
`ifdef DCACHE_CTRL_STATS_EN
        , .hitCount(hitCount), .missCount(missCount), .evictCount(evictCount)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural data_cache: registered status one cycle after the drive
    logic       c_valid [1024];
    logic       c_dirty [1024];
    logic [17:0]  c_tag  [1024];
    logic [511:0] c_data [1024];
    logic [9:0] ci;
    logic [17:0] ct;
    logic [3:0] co;
    assign ci = cacheAddr[13:4];
    assign ct = cacheAddr[31:14];
    assign co = cacheAddr[3:0];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 1024; i++) begin
                c_valid[i] <= 1'b0;
                c_dirty[i] <= 1'b0;
            end
            cacheHit <= 1'b0; cacheMiss <= 1'b0; cacheEvict <= 1'b0;
            cacheDataOut <= 32'd0; cacheBlkOut <= 512'd0; cacheTagOut <= 18'd0;
        end else begin
            cacheHit <= 1'b0; cacheMiss <= 1'b0; cacheEvict <= 1'b0;
            if (cacheEn) begin
                if (cacheLd) begin
                    c_valid[ci] <= 1'b1; c_dirty[ci] <= 1'b0;
                    c_tag[ci] <= ct; c_data[ci] <= cacheBlkIn;
                end else if (c_valid[ci] && c_tag[ci] == ct) begin
                    cacheHit <= 1'b1;
                    cacheDataOut <= c_data[ci][{co, 5'd0} +: 32];
                    if (cacheWr) begin
                        c_data[ci][{co, 5'd0} +: 32] <= cacheDataIn;
                        c_dirty[ci] <= 1'b1;
                    end
                end else begin
                    cacheMiss <= 1'b1;
                    cacheEvict <= c_valid[ci] && c_dirty[ci];
                    cacheBlkOut <= c_data[ci];
                    cacheTagOut <= c_tag[ci];
                end
            end
        end
    end

    // Behavioural memory: unwritten word at address a holds the value a
    logic [511:0] m_line [4096];
    logic         m_flag [4096];
    int           mem_cnt;
    logic [11:0]  mi;
    assign mi = memAddr[15:4];

    function automatic logic [511:0] dflt_line(input logic [31:0] base);
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[k*32 +: 32] = base + 32'(k);
        return b;
    endfunction

    always_comb memBlkIn = m_flag[mi] ? m_line[mi] : dflt_line({memAddr[31:4], 4'h0});
    assign memAck = stray_ack | (memRd && (mem_cnt == lat_f - 1)) | (memWr && (mem_cnt == lat_w - 1));

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_cnt <= 0;
            for (int i = 0; i < 4096; i++) m_flag[i] <= 1'b0;
        end else begin
            if (memRd || memWr) mem_cnt <= memAck ? 0 : mem_cnt + 1;
            else mem_cnt <= 0;
            if (memWr && memAck) begin
                m_line[mi] <= memBlkOut;
                m_flag[mi] <= 1'b1;
            end
        end
    end

    // Reference model: CPU-visible word values and per-index residency
    logic [31:0] ref_word [bit [31:0]];
    bit          ref_valid [1024];
    bit          ref_dirty [1024];
    logic [17:0] ref_tag   [1024];
    int exp_hits = 0, exp_misses = 0, exp_evicts = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_word.exists(a) ? ref_word[a] : a;
    endfunction

    function automatic logic [511:0] exp_line(input logic [31:0] base);
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[k*32 +: 32] = ref_rd(base + 32'(k));
        return b;
    endfunction

    task automatic ref_clear();
        ref_word.delete();
        for (int i = 0; i < 1024; i++) begin ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; end
        exp_hits = 0; exp_misses = 0; exp_evicts = 0;
    endtask

    task automatic predict(input logic [31:0] a, output bit hit, output bit ev, output logic [31:0] vaddr);
        int idx = int'(a[13:4]);
        hit   = ref_valid[idx] && (ref_tag[idx] == a[31:14]);
        ev    = !hit && ref_valid[idx] && ref_dirty[idx];
        vaddr = {ref_tag[idx], a[13:4], 4'h0};
    endtask

    task automatic commit(input logic [31:0] a, input logic w, input logic [31:0] d);
        bit hit, ev;
        logic [31:0] va;
        int idx = int'(a[13:4]);
        predict(a, hit, ev, va);
        if (hit) exp_hits++; else exp_misses++;
        if (ev) exp_evicts++;
        if (!hit) begin ref_valid[idx] = 1'b1; ref_tag[idx] = a[31:14]; ref_dirty[idx] = 1'b0; end
        if (w) begin ref_word[a] = d; ref_dirty[idx] = 1'b1; end
    endtask

    typedef struct {
        int lat; logic [31:0] data; int n_wr; int n_rd; int n_ld; int n_en;
        int overlap; int order_bad; int ctl_bad; int timeout;
        logic [31:0] wb_addr; logic [511:0] wb_blk; logic [31:0] rd_addr;
    } obs_t;

    // Issue one request in IDLE and observe every cycle until cpuDone
    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input int wl, input int fl, output obs_t o);
        bit done = 1'b0;
        int guard = 0;
        o = '{default: 0};
        lat_w = wl; lat_f = fl;
        while (busy === 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        cpuReq = 1'b1; cpuWr = w; cpuAddr = a; cpuDataIn = d;
        @(posedge clk); #1;
        o.lat = 1;
        for (int c = 0; c < 200 && !done; c++) begin
            if (memWr) begin
                if (o.n_wr == 0) begin o.wb_addr = memAddr; o.wb_blk = memBlkOut; end
                o.n_wr++;
                if (o.n_rd > 0) o.order_bad++;
            end
            if (memRd) begin
                if (o.n_rd == 0) o.rd_addr = memAddr;
                o.n_rd++;
            end
            if (memRd && memWr) o.overlap++;
            if (cacheLd) o.n_ld++;
            if (cacheEn) o.n_en++;
            if (cacheEn && !cacheLd && (cacheRd === cacheWr || cacheWr !== w)) o.ctl_bad++;
            if (cpuDone) begin
                done = 1'b1;
                o.data = cpuDataOut;
            end else begin
                @(posedge clk); #1;
                o.lat++;
            end
        end
        if (!done) o.timeout = 1;
        cpuReq = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        bit saw_rd = 1'b0;
        rst = 1'b0;
        #3;
        n_total++;
        if ({cpuDone, busy, memRd, memWr, cacheEn, cacheRd, cacheWr, cacheLd} !== 8'd0)
            $display("FAIL reset_ctl got %b exp 00000000", {cpuDone, busy, memRd, memWr, cacheEn, cacheRd, cacheWr, cacheLd});
        else n_pass++;
        n_total++;
        if ({cpuDataOut, memAddr, cacheAddr, cacheDataIn} !== 128'd0)
            $display("FAIL reset_data got %h exp 0", {cpuDataOut, memAddr, cacheAddr, cacheDataIn});
        else n_pass++;
        n_total++;
        if ((memBlkOut | cacheBlkIn) !== 512'd0) $display("FAIL reset_blk got %h exp 0", memBlkOut | cacheBlkIn);
        else n_pass++;
        ref_clear();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        // start a miss and reset it while FILL is waiting for memory
        lat_f = 40;
        cpuReq = 1'b1; cpuWr = 1'b0; cpuAddr = 32'h0000_0306; cpuDataIn = 32'd0;
        for (int c = 0; c < 20 && !saw_rd; c++) begin @(posedge clk); #1; saw_rd = memRd; end
        n_total++;
        if (saw_rd !== 1'b1) $display("FAIL midfill_memrd got %b exp 1", saw_rd); else n_pass++;
        @(posedge clk); #3;
        rst = 1'b0; cpuReq = 1'b0;
        #1;
        n_total++;
        if ({memRd, busy, cpuDone} !== 3'b000) $display("FAIL async_drop got %b exp 000", {memRd, busy, cpuDone});
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; stray_ack = 1'b1;
        @(posedge clk); #1; stray_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (busy || cpuDone || memRd || memWr || cacheEn) bad++;
            @(posedge clk); #1;
        end
        n_total++;
        if (bad !== 0) $display("FAIL stray_ack active_cycles got %0d exp 0", bad); else n_pass++;
    endtask

    task automatic test_cold_load();
        obs_t o;
        do_req(32'h0000_0016, 1'b0, 32'd0, 1, 4, o);
        n_total++; if (o.timeout !== 0) $display("FAIL cold_timeout got %0d exp 0", o.timeout); else n_pass++;
        n_total++; if (o.rd_addr !== 32'h0000_0010) $display("FAIL cold_memaddr got %h exp 00000010", o.rd_addr); else n_pass++;
        n_total++; if (o.n_ld !== 1) $display("FAIL cold_ld_cycles got %0d exp 1", o.n_ld); else n_pass++;
        n_total++; if (o.data !== 32'd22) $display("FAIL cold_data got %0d exp 22", o.data); else n_pass++;
        n_total++; if (o.lat !== 10) $display("FAIL cold_latency got %0d exp 10", o.lat); else n_pass++;
        n_total++; if (o.n_wr !== 0) $display("FAIL cold_memwr got %0d exp 0", o.n_wr); else n_pass++;
        commit(32'h0000_0016, 1'b0, 32'd0);
    endtask

    task automatic test_hit();
        obs_t o;
        do_req(32'h0000_0011, 1'b0, 32'd0, 1, 1, o);
        n_total++; if (o.data !== 32'd17) $display("FAIL hit_data got %0d exp 17", o.data); else n_pass++;
        n_total++; if (o.lat !== 3) $display("FAIL hit_latency got %0d exp 3", o.lat); else n_pass++;
        n_total++; if (o.n_rd + o.n_wr !== 0) $display("FAIL hit_mem_cycles got %0d exp 0", o.n_rd + o.n_wr); else n_pass++;
        n_total++; if (o.n_en !== 1) $display("FAIL hit_en_cycles got %0d exp 1", o.n_en); else n_pass++;
        commit(32'h0000_0011, 1'b0, 32'd0);
    endtask

    task automatic test_store_load();
        obs_t o;
        do_req(32'h0000_0011, 1'b1, 32'hFFFF_FFFF, 1, 1, o);
        n_total++; if (o.lat !== 3) $display("FAIL store_latency got %0d exp 3", o.lat); else n_pass++;
        n_total++; if (o.ctl_bad !== 0) $display("FAIL store_ctl got %0d exp 0", o.ctl_bad); else n_pass++;
        commit(32'h0000_0011, 1'b1, 32'hFFFF_FFFF);
        do_req(32'h0000_0011, 1'b0, 32'd0, 1, 1, o);
        n_total++; if (o.data !== 32'hFFFF_FFFF) $display("FAIL store_readback got %h exp ffffffff", o.data); else n_pass++;
        n_total++; if (o.lat !== 3) $display("FAIL readback_latency got %0d exp 3", o.lat); else n_pass++;
        commit(32'h0000_0011, 1'b0, 32'd0);
    endtask

    task automatic test_evict();
        obs_t o;
        logic [511:0] eb;
        // dirty tag-0 line at index 1 is evicted by tag 1
        for (int k = 0; k < 16; k++) eb[k*32 +: 32] = (k == 1) ? 32'hFFFF_FFFF : 32'h10 + 32'(k);
        do_req(32'h0000_4012, 1'b0, 32'd0, 2, 1, o);
        n_total++; if (o.wb_addr !== 32'h0000_0010) $display("FAIL evict0_addr got %h exp 00000010", o.wb_addr); else n_pass++;
        n_total++; if (o.wb_blk !== eb) $display("FAIL evict0_blk got %h exp %h", o.wb_blk, eb); else n_pass++;
        n_total++; if (o.lat !== 9) $display("FAIL evict0_latency got %0d exp 9", o.lat); else n_pass++;
        n_total++; if (o.data !== 32'h0000_4012) $display("FAIL evict0_data got %h exp 00004012", o.data); else n_pass++;
        commit(32'h0000_4012, 1'b0, 32'd0);
        do_req(32'h0000_4013, 1'b1, 32'hA5A5_0013, 1, 1, o);
        commit(32'h0000_4013, 1'b1, 32'hA5A5_0013);
        // dirty tag-1 line at index 1 is evicted by tag 2
        for (int k = 0; k < 16; k++) eb[k*32 +: 32] = (k == 3) ? 32'hA5A5_0013 : 32'h4010 + 32'(k);
        do_req(32'h0000_8015, 1'b0, 32'd0, 3, 2, o);
        n_total++; if (o.wb_addr !== 32'h0000_4010) $display("FAIL evict1_addr got %h exp 00004010", o.wb_addr); else n_pass++;
        n_total++; if (o.wb_blk !== eb) $display("FAIL evict1_blk got %h exp %h", o.wb_blk, eb); else n_pass++;
        n_total++; if (o.order_bad + o.overlap !== 0) $display("FAIL evict1_order got %0d exp 0", o.order_bad + o.overlap); else n_pass++;
        n_total++; if ({o.n_wr, o.n_rd} !== {32'd3, 32'd2}) $display("FAIL evict1_mem_cycles got %0d/%0d exp 3/2", o.n_wr, o.n_rd); else n_pass++;
        n_total++; if (o.rd_addr !== 32'h0000_8010) $display("FAIL evict1_rdaddr got %h exp 00008010", o.rd_addr); else n_pass++;
        n_total++; if (o.lat !== 11) $display("FAIL evict1_latency got %0d exp 11", o.lat); else n_pass++;
        n_total++; if (o.data !== 32'h0000_8015) $display("FAIL evict1_data got %h exp 00008015", o.data); else n_pass++;
        commit(32'h0000_8015, 1'b0, 32'd0);
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            do_req(32'h0000_8010 + 32'(i * 5), 1'b0, 32'd0, 1, 1, o);
            n_total++;
            if (o.lat !== 3 || o.data !== 32'h0000_8010 + 32'(i * 5))
                $display("FAIL b2b[%0d] got lat %0d data %h exp lat 3 data %h", i, o.lat, o.data, 32'h0000_8010 + 32'(i * 5));
            else n_pass++;
            commit(32'h0000_8010 + 32'(i * 5), 1'b0, 32'd0);
        end
    endtask

    task automatic test_random();
        obs_t o;
        bit hit, ev;
        logic [31:0] a, d, va;
        logic [511:0] vb;
        logic w;
        int wl, fl, el;
        for (int i = 0; i < 80; i++) begin
            a  = {14'd0, 2'($urandom_range(0, 3)), 8'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            wl = $urandom_range(1, 4);
            fl = $urandom_range(1, 4);
            predict(a, hit, ev, va);
            vb = exp_line(va);
            el = hit ? 3 : (3 + (ev ? wl : 0) + fl + 3);
            do_req(a, w, d, wl, fl, o);
            n_total++; if (o.lat !== el) $display("FAIL rnd_lat[%0d] got %0d exp %0d", i, o.lat, el); else n_pass++;
            n_total++;
            if (o.n_wr !== (ev ? wl : 0) || o.n_rd !== (hit ? 0 : fl))
                $display("FAIL rnd_mem[%0d] got wr %0d rd %0d exp wr %0d rd %0d", i, o.n_wr, o.n_rd, ev ? wl : 0, hit ? 0 : fl);
            else n_pass++;
            n_total++;
            if (o.n_ld !== (hit ? 0 : 1) || o.n_en !== (hit ? 1 : 3))
                $display("FAIL rnd_cache[%0d] got ld %0d en %0d exp ld %0d en %0d", i, o.n_ld, o.n_en, hit ? 0 : 1, hit ? 1 : 3);
            else n_pass++;
            n_total++;
            if (o.overlap + o.order_bad + o.ctl_bad !== 0)
                $display("FAIL rnd_proto[%0d] got %0d/%0d/%0d exp 0/0/0", i, o.overlap, o.order_bad, o.ctl_bad);
            else n_pass++;
            if (!w) begin
                n_total++;
                if (o.data !== ref_rd(a)) $display("FAIL rnd_data[%0d] got %h exp %h", i, o.data, ref_rd(a)); else n_pass++;
            end
            if (!hit) begin
                n_total++;
                if (o.rd_addr !== {a[31:4], 4'h0}) $display("FAIL rnd_rdaddr[%0d] got %h exp %h", i, o.rd_addr, {a[31:4], 4'h0}); else n_pass++;
            end
            if (ev) begin
                n_total++;
                if (o.wb_addr !== va || o.wb_blk !== vb)
                    $display("FAIL rnd_wb[%0d] got %h %h exp %h %h", i, o.wb_addr, o.wb_blk, va, vb);
                else n_pass++;
            end
            commit(a, w, d);
        end
    endtask

    task automatic test_stats();
`ifdef DCACHE_CTRL_STATS_EN
        n_total++;
        if ({hitCount, missCount, evictCount} !== {32'(exp_hits), 32'(exp_misses), 32'(exp_evicts)})
            $display("FAIL stats got %0d/%0d/%0d exp %0d/%0d/%0d", hitCount, missCount, evictCount, exp_hits, exp_misses, exp_evicts);
        else n_pass++;
`endif
    endtask

    initial begin
        cpuReq = 1'b0; cpuWr = 1'b0; cpuAddr = 32'd0; cpuDataIn = 32'd0;
        test_reset();
        test_cold_load();
        test_hit();
        test_store_load();
        test_evict();
        test_stats();
        test_back_to_back();
        test_random();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
